// File: rtl/serdesphy_rx_sync_fifo.sv
// Single-clock RX FIFO with occupancy count, watermarks, flush and sticky errors.
// Define SERDESPHY_RX_FIFO_FWFT_EN for first-word-fall-through reads (default: registered reads).
module serdesphy_rx_sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  clr_sticky,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int LW    = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  isFull, isEmpty;
   logic                  rdAcc, wrAcc;

   assign isEmpty = (level_q == '0);
   assign isFull  = (level_q == LW'(DEPTH));

   // A write into a full FIFO is still taken when a read frees a slot on the same edge.
   assign rdAcc = rd_en & ~isEmpty;
   assign wrAcc = wr_en & (~isFull | rdAcc);

   assign full         = isFull;
   assign empty        = isEmpty;
   assign almost_full  = (level_q >= LW'(AF_THRESH));
   assign almost_empty = (level_q <= LW'(AE_THRESH));
   assign level        = level_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   always_comb begin
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      level_d     = level_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         level_d = '0;
      end else begin
         if (wrAcc) begin
            wrPtr_d = wrPtr_q + 1'b1;
         end
         if (rdAcc) begin
            rdPtr_d = rdPtr_q + 1'b1;
         end
         case ({wrAcc, rdAcc})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
         // Setting has priority over clearing so no error event is lost.
         if (clr_sticky) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
         end
         if (wr_en & ~wrAcc) begin
            overflow_d = 1'b1;
         end
         if (rd_en & isEmpty) begin
            underflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wrAcc & ~flush) begin
         mem_q[wrPtr_q] <= wr_data;
      end
   end

`ifdef SERDESPHY_RX_FIFO_FWFT_EN
   assign rd_data  = isEmpty ? '0 : mem_q[rdPtr_q];
   assign rd_valid = ~isEmpty;
`else
   logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
   logic                  rdValid_q, rdValid_d;

   always_comb begin
      rdValid_d = rdAcc & ~flush;
      rdData_d  = rdData_q;
      if (rdAcc & ~flush) begin
         rdData_d = mem_q[rdPtr_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdData_q  <= '0;
         rdValid_q <= 1'b0;
      end else begin
         rdData_q  <= rdData_d;
         rdValid_q <= rdValid_d;
      end
   end

   assign rd_data  = rdData_q;
   assign rd_valid = rdValid_q;
`endif

endmodule

// File: tb/tb_serdesphy_rx_sync_fifo.sv
// Self-checking bench for serdesphy_rx_sync_fifo: queue-based reference model plus directed literal checks.
// Honours SERDESPHY_RX_FIFO_FWFT_EN the same way the design does.
`timescale 1ns/1ps
module tb_serdesphy_rx_sync_fifo;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 1;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          clr_sticky;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   level;
   logic          overflow;
   logic          underflow;

   int total;
   int bad;

   serdesphy_rx_sync_fifo #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .AF_THRESH (AF),
      .AE_THRESH (AE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .clr_sticky  (clr_sticky),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .level       (level),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial clk = 1'b0;
   always #21 clk = ~clk;

   // Reference model: the FIFO is just a queue of words plus a few flags.
   logic [DW-1:0] mq[$];
   logic          mOvf;
   logic          mUdf;
   logic          mRv;
   logic [DW-1:0] mRd;
   logic          mRa;
   logic          mWa;
   logic          mUdfSet;
   logic          mOvfSet;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         mOvf = 1'b0;
         mUdf = 1'b0;
         mRv  = 1'b0;
         mRd  = '0;
      end else if (flush) begin
         mq.delete();
         mRv = 1'b0;
      end else begin
         mRa     = rd_en && (mq.size() > 0);
         mWa     = wr_en && ((mq.size() < DEPTH) || mRa);
         mUdfSet = rd_en && (mq.size() == 0);
         mOvfSet = wr_en && !mWa;
         mRv     = mRa;
         if (mRa) mRd = mq.pop_front();
         if (mWa) mq.push_back(wr_data);
         mOvf = mOvfSet ? 1'b1 : (clr_sticky ? 1'b0 : mOvf);
         mUdf = mUdfSet ? 1'b1 : (clr_sticky ? 1'b0 : mUdf);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every falling edge: DUT outputs against the model.
   always @(negedge clk) begin
      int lvl;
      lvl = mq.size();
      checkOutput("level", 32'(level), 32'(lvl));
      checkOutput("full", 32'(full), 32'(lvl == DEPTH));
      checkOutput("empty", 32'(empty), 32'(lvl == 0));
      checkOutput("almost_full", 32'(almost_full), 32'(lvl >= AF));
      checkOutput("almost_empty", 32'(almost_empty), 32'(lvl <= AE));
      checkOutput("overflow", 32'(overflow), 32'(mOvf));
      checkOutput("underflow", 32'(underflow), 32'(mUdf));
`ifdef SERDESPHY_RX_FIFO_FWFT_EN
      checkOutput("rd_valid", 32'(rd_valid), 32'(lvl > 0));
      checkOutput("rd_data", 32'(rd_data), (lvl > 0) ? 32'(mq[0]) : 32'h0);
`else
      checkOutput("rd_valid", 32'(rd_valid), 32'(mRv));
      checkOutput("rd_data", 32'(rd_data), 32'(mRd));
`endif
   end

   task automatic applyStimulus(input logic w, input logic [DW-1:0] d, input logic r,
                                input logic f, input logic c);
      @(negedge clk);
      wr_en      = w;
      wr_data    = d;
      rd_en      = r;
      flush      = f;
      clr_sticky = c;
   endtask

   task automatic idle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".level"}, 32'(level), 32'h0);
      checkOutput({tag, ".empty"}, 32'(empty), 32'h1);
      checkOutput({tag, ".almost_empty"}, 32'(almost_empty), 32'h1);
      checkOutput({tag, ".full"}, 32'(full), 32'h0);
      checkOutput({tag, ".almost_full"}, 32'(almost_full), 32'h0);
      checkOutput({tag, ".overflow"}, 32'(overflow), 32'h0);
      checkOutput({tag, ".underflow"}, 32'(underflow), 32'h0);
      checkOutput({tag, ".rd_valid"}, 32'(rd_valid), 32'h0);
      checkOutput({tag, ".rd_data"}, 32'(rd_data), 32'h0);
   endtask

   task automatic fillFrom(input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, base + DW'(i), 1'b0, 1'b0, 1'b0);
      idle();
   endtask

   task automatic readExpect(input string name, input logic [DW-1:0] exp);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle();
      checkOutput({name, ".rd_valid"}, 32'(rd_valid), 32'h1);
      checkOutput({name, ".rd_data"}, 32'(rd_data), 32'(exp));
   endtask

   initial begin
      logic w, r, f, c;
      int   wrPct, rdPct;
      total      = 0;
      bad        = 0;
      rst_n      = 1'b0;
      flush      = 1'b0;
      clr_sticky = 1'b0;
      wr_en      = 1'b0;
      wr_data    = '0;
      rd_en      = 1'b0;
      repeat (3) @(negedge clk);
      checkResetValues("reset");
      rst_n = 1'b1;

`ifdef SERDESPHY_RX_FIFO_FWFT_EN
      applyStimulus(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
      checkOutput("fwft.first.rd_valid", 32'(rd_valid), 32'h1);
      checkOutput("fwft.first.rd_data", 32'(rd_data), 32'h42);
      idle();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle();
      checkOutput("fwft.second.rd_data", 32'(rd_data), 32'h43);
      checkOutput("fwft.second.rd_valid", 32'(rd_valid), 32'h1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle();
      checkOutput("fwft.drained.rd_valid", 32'(rd_valid), 32'h0);
      checkOutput("fwft.drained.empty", 32'(empty), 32'h1);
`else
      fillFrom(8'h11, 8);
      checkOutput("fill.level", 32'(level), 32'h8);
      checkOutput("fill.full", 32'(full), 32'h1);
      checkOutput("fill.almost_full", 32'(almost_full), 32'h1);
      for (int i = 0; i < 8; i++) readExpect("order", 8'h11 + 8'(i));
      checkOutput("drain.empty", 32'(empty), 32'h1);
      checkOutput("drain.almost_empty", 32'(almost_empty), 32'h1);

      fillFrom(8'h21, 8);
      applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
      idle();
      checkOutput("ovf.overflow", 32'(overflow), 32'h1);
      checkOutput("ovf.level", 32'(level), 32'h8);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      idle();
      checkOutput("clr.overflow", 32'(overflow), 32'h0);
      for (int i = 0; i < 8; i++) readExpect("no99", 8'h21 + 8'(i));

      fillFrom(8'h31, 8);
      applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      idle();
      checkOutput("fullrw.level", 32'(level), 32'h8);
      checkOutput("fullrw.overflow", 32'(overflow), 32'h0);
      checkOutput("fullrw.rd_data", 32'(rd_data), 32'h31);
      for (int i = 0; i < 8; i++) readExpect("fullrw.order", (i < 7) ? 8'h32 + 8'(i) : 8'hAA);

      applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
      idle();
      checkOutput("emptyrw.underflow", 32'(underflow), 32'h1);
      checkOutput("emptyrw.level", 32'(level), 32'h1);
      checkOutput("emptyrw.rd_valid", 32'(rd_valid), 32'h0);
      readExpect("emptyrw.read", 8'h5A);

      fillFrom(8'h61, 5);
      applyStimulus(1'b1, 8'h70, 1'b0, 1'b1, 1'b0);
      idle();
      checkOutput("flush.level", 32'(level), 32'h0);
      checkOutput("flush.empty", 32'(empty), 32'h1);
      checkOutput("flush.underflow", 32'(underflow), 32'h1);
      checkOutput("flush.overflow", 32'(overflow), 32'h0);
      checkOutput("flush.rd_valid", 32'(rd_valid), 32'h0);
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      readExpect("postflush", 8'h33);
`endif

      // Asynchronous reset in the middle of a write burst.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #5 rst_n = 1'b0;
      #1 checkResetValues("midreset");
      wr_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic alternating between fill-biased and drain-biased phases.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         wrPct = ((cyc / 150) % 2 == 0) ? 75 : 30;
         rdPct = ((cyc / 150) % 2 == 0) ? 30 : 75;
         w = ($urandom_range(99, 0) < 32'(wrPct));
         r = ($urandom_range(99, 0) < 32'(rdPct));
         f = ($urandom_range(63, 0) == 0);
         c = ($urandom_range(31, 0) == 0);
         applyStimulus(w, DW'($urandom_range(255, 0)), r, f, c);
      end
      idle();
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serdesphy_rx_sync_fifo.md
Name: serdesphy_rx_sync_fifo

Overview:
- Parametrised single-clock receive FIFO for the next-generation RX datapath.
- Placed after the CDC stage, where all traffic is already in the 24 MHz system domain.
- Adds over the previous RX FIFO: configurable width and depth, an occupancy count, almost-full/almost-empty watermarks, a synchronous flush, and clearable sticky error flags.
- An optional first-word-fall-through read mode is selected by macro.

Parameters:
- DATA_WIDTH, 8, data word width in bits (>=1).
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (>=1).
- AF_THRESH, 6, almost_full asserts when level >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  input  1  system clock (24 MHz), rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous flush: discards all contents.
- clr_sticky  input  1  clears overflow/underflow.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write data.
- rd_en  input  1  read request (pop).
- rd_data  output  DATA_WIDTH  read data.
- rd_valid  output  1  rd_data valid qualifier.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- almost_full  output  1  level >= AF_THRESH.
- almost_empty  output  1  level <= AE_THRESH.
- level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: write rejected because full.
- underflow  output  1  sticky: read rejected because empty.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state: pointers = 0; level = 0; empty = 1; almost_empty = 1; full = 0; almost_full = 0; overflow = 0; underflow = 0; rd_valid = 0; rd_data = 0. Memory contents are not reset.
- Reset mid-operation: all queued data is lost; outputs take reset values immediately.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap modulo DEPTH. level is a separate (ADDR_WIDTH+1)-bit registered counter.
- Read accept: rd_acc = rd_en & !empty.
- Write accept: wr_acc = wr_en & (!full | rd_acc).
  - Full with simultaneous read and write: both accepted, level unchanged.
  - Empty with simultaneous read and write: write accepted, read rejected.
- level update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Flags: full, empty, almost_full and almost_empty are decoded from the registered level. They reflect the state after each edge, with no extra pipeline delay.
- Sticky errors:
  - overflow sets on wr_en & !wr_acc.
  - underflow sets on rd_en & empty.
  - Both clear on clr_sticky.
  - If set and clear occur in the same cycle, set wins.
- flush (highest priority besides reset):
  - Pointers and level go to 0; wr_en and rd_en that cycle are ignored.
  - Sticky flags are untouched; rd_valid = 0 next cycle.
  - A write on the cycle after flush deasserts is accepted normally.
- Default read mode (registered, 1-cycle latency):
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid = 1 on the next cycle.
  - rd_valid = 0 on any cycle following a non-accepted read.
  - rd_data holds its last value when no read is accepted.
- Write-to-read latency: a word written at edge N is readable (empty = 0) at edge N+1.

Optional Feature:
- Macro: SERDESPHY_RX_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rd_data = mem[rd_ptr], combinational from registers.
  - rd_valid = !empty.
  - rd_en acts as an acknowledge: it pops the current head, and the next word appears at the following edge.
  - Underflow rules are unchanged.
- Undefined: the registered 1-cycle-latency read mode described above.

Test Plan:
- Defaults (8x8). Write 0x11..0x18 in 8 cycles, then read 8 cycles.
  - After the writes: level = 8, full = 1, almost_full = 1.
  - Reads return 0x11..0x18 in order, rd_valid one cycle after each rd_en.
  - Then empty = 1, almost_empty = 1.
- Full, then wr_en with 0x99 and no read.
  - overflow = 1, level stays 8, 0x99 is never read back.
  - Next, pulse clr_sticky: overflow = 0.
- Full, then rd_en and wr_en (0xAA) in the same cycle.
  - level stays 8, no overflow.
  - 0xAA is the 8th word read afterwards.
- Empty, then rd_en and wr_en (0x5A) in the same cycle.
  - underflow = 1, level = 1, rd_valid = 0.
  - The next read returns 0x5A.
- Write 5 words, assert flush together with wr_en.
  - level = 0, empty = 1, sticky flags unchanged.
  - Write 0x33 and read: returns 0x33.
  - Assert rst_n low mid-burst: all outputs at reset values immediately.
- With SERDESPHY_RX_FIFO_FWFT_EN defined, write 0x42, 0x43.
  - On the edge after the first write: rd_valid = 1, rd_data = 0x42 with no rd_en.
  - Pulse rd_en: rd_data = 0x43 next cycle.
  - Pulse rd_en again: rd_valid = 0.
